// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 pattern transmitter and the matching sequence detector.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_FIN   = 2'd3
    } tx_state_t;

    // Overlapping Mealy detector states, named by the longest matched prefix of 1011.
    typedef enum logic [1:0] {
        DS_S0    = 2'd0,
        DS_S1    = 2'd1,
        DS_S10   = 2'd2,
        DS_S101  = 2'd3
    } det_state_t;

    localparam logic [3:0] DEF_PAT = 4'b1011;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero; zero_o flags a count of 0.
module seq_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = d_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen_1011_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times, with optional idle gaps.
// Outputs are registered; the first bit appears one cycle after start is accepted.
module seq_gen_1011_tx
    import seq_pkg::*;
#(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       st
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    tx_state_t        state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic idx_load, idx_en, idx_zero;
    logic gap_load, gap_en, gap_zero;
    logic reps_load, reps_en, reps_zero;

    seq_down_cnt #(.W(IDX_W)) u_idx_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (idx_load),
        .en_i   (idx_en),
        .d_i    (IDX_W'(PAT_W - 1)),
        .zero_o (idx_zero)
    );

    seq_down_cnt #(.W(CNT_W)) u_gap_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (gap_load),
        .en_i   (gap_en),
        .d_i    (gap_q - CNT_W'(1)),
        .zero_o (gap_zero)
    );

    // Holds the number of reps still to follow the current one; zero marks the last rep.
    seq_down_cnt #(.W(CNT_W)) u_reps_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (reps_load),
        .en_i   (reps_en),
        .d_i    (reps - CNT_W'(1)),
        .zero_o (reps_zero)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        sh_d      = sh_q;
        gap_d     = gap_q;
        x_d       = IDLE_BIT;
        xv_d      = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        idx_load  = 1'b0;
        idx_en    = 1'b0;
        gap_load  = 1'b0;
        gap_en    = 1'b0;
        reps_load = 1'b0;
        reps_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        pat_d     = pattern;
                        gap_d     = gap;
                        sh_d      = pattern << 1;
                        reps_load = 1'b1;
                        idx_load  = 1'b1;
                        x_d       = pattern[PAT_W-1];
                        xv_d      = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = ST_SHIFT;
                    end else begin
                        done_d    = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (!idx_zero) begin
                    idx_en = 1'b1;
                    x_d    = sh_q[PAT_W-1];
                    sh_d   = sh_q << 1;
                    xv_d   = 1'b1;
                    busy_d = 1'b1;
                end else if (reps_zero) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    reps_en = 1'b1;
                    busy_d  = 1'b1;
                    if (gap_q != '0) begin
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        idx_load = 1'b1;
                        x_d      = pat_q[PAT_W-1];
                        sh_d     = pat_q << 1;
                        xv_d     = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_zero) begin
                    idx_load = 1'b1;
                    x_d      = pat_q[PAT_W-1];
                    sh_d     = pat_q << 1;
                    xv_d     = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    gap_en = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            sh_d      = sh_q;
            x_d       = IDLE_BIT;
            xv_d      = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            idx_load  = 1'b0;
            idx_en    = 1'b0;
            gap_load  = 1'b0;
            gap_en    = 1'b0;
            reps_load = 1'b0;
            reps_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            gap_q   <= '0;
            x_q     <= IDLE_BIT;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign st      = state_q;

endmodule
